// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control unit.
// Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath selects from the latched instruction. Memory accesses use a
// req/ack handshake guarded by a watchdog that traps after MEM_TIMEOUT cycles.
// Optional feature: define MC_CONTROL_CSR_EN to accept SYSTEM (CSR) opcodes.
module mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        IRWen,
  output logic        PCWen,
  output logic        PCSel,
  output logic        RegWen,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic        CSRSel,
  output logic [2:0]  ImmSel,
  output logic [3:0]  ALUSel,
  output logic [3:0]  MemRW,
  output logic [2:0]  WBSel,
  output logic        retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  // Datapath select encodings shared with the rest of the core (common_define.h).
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3,
                         IMM_J = 3'd4, IMM_CSR = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] MEM_READ = 4'b0000, MEM_WRITE_B = 4'b0001,
                         MEM_WRITE_H = 4'b0011, MEM_WRITE_W = 4'b1111;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC_NEXT = 3'd2, WB_CSR = 3'd3;

  localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LOAD = 5'b00000,
                         OP_STORE = 5'b01000, OP_BRANCH = 5'b11000, OP_JAL = 5'b11011,
                         OP_JALR = 5'b11001, OP_AUIPC = 5'b00101, OP_LUI = 5'b01101,
                         OP_CSR = 5'b11100;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [TO_W-1:0] r_wdog;
  logic            r_trap;
  logic [1:0]      r_cause;

  logic [4:0] w_opc;
  logic [2:0] w_f3;
  logic       w_b30;
  logic       w_isCsr;
  logic       w_legal;
  logic       w_isLoad;
  logic       w_isStore;
  logic       w_isBranch;
  logic       w_isJump;
  logic       w_taken;
  logic       w_wdogHit;
  logic       w_unused;

  logic [2:0] w_immSel;
  logic [3:0] w_aluSel;
  logic       w_aSel;
  logic       w_bSel;
  logic       w_brUn;
  logic [2:0] w_wbSel;
  logic       w_csrSel;
  logic [3:0] w_storeCode;

  assign w_opc    = instruction[6:2];
  assign w_f3     = instruction[14:12];
  assign w_b30    = instruction[30];
  assign w_unused = &{instruction[31], instruction[29:15], instruction[11:7], instruction[1:0]};

`ifdef MC_CONTROL_CSR_EN
  assign w_isCsr = (w_opc == OP_CSR);
`else
  assign w_isCsr = 1'b0;
`endif

  assign w_isLoad   = (w_opc == OP_LOAD);
  assign w_isStore  = (w_opc == OP_STORE);
  assign w_isBranch = (w_opc == OP_BRANCH);
  assign w_isJump   = (w_opc == OP_JAL) || (w_opc == OP_JALR);
  assign w_legal    = (w_opc == OP_R) || (w_opc == OP_I) || w_isLoad || w_isStore ||
                      w_isBranch || w_isJump || (w_opc == OP_AUIPC) ||
                      (w_opc == OP_LUI) || w_isCsr;

  assign mem_req    = (r_state == S_FETCH) || (r_state == S_MEM);
  // The hit fires on the last permitted wait cycle so an ack in that same cycle still wins.
  assign w_wdogHit  = (MEM_TIMEOUT != 0) && ((int'(r_wdog) + 1) == MEM_TIMEOUT);
  assign trap       = r_trap;
  assign trap_cause = r_cause;

  // Branch condition from the comparator flags, selected by funct3.
  always_comb begin
    case (w_f3)
      3'b000:         w_taken = BrEq;
      3'b001:         w_taken = !BrEq;
      3'b100, 3'b110: w_taken = BrLt;
      3'b101, 3'b111: w_taken = !BrLt;
      default:        w_taken = 1'b0;
    endcase
  end

  // Datapath select decode from the instruction register, as in the single-cycle decoder.
  always_comb begin
    w_immSel = IMM_I;
    w_aluSel = ALU_ADD;
    w_aSel   = 1'b0;
    w_bSel   = 1'b1;
    w_brUn   = 1'b0;
    w_wbSel  = WB_ALU;
    w_csrSel = 1'b0;
    case (w_f3)
      3'b000:  w_storeCode = MEM_WRITE_B;
      3'b001:  w_storeCode = MEM_WRITE_H;
      default: w_storeCode = MEM_WRITE_W;
    endcase
    case (w_opc)
      OP_R: begin
        w_aluSel = {w_b30, w_f3};
        w_bSel   = 1'b0;
      end
      OP_I:      w_aluSel = {(w_f3 == 3'b101) && w_b30, w_f3};
      OP_LOAD:   w_wbSel  = WB_MEM;
      OP_STORE:  w_immSel = IMM_S;
      OP_BRANCH: begin
        w_immSel = IMM_B;
        w_aSel   = 1'b1;
        w_brUn   = w_f3[2] && w_f3[1];
      end
      OP_JAL: begin
        w_immSel = IMM_J;
        w_aSel   = 1'b1;
        w_wbSel  = WB_PC_NEXT;
      end
      OP_JALR:   w_wbSel  = WB_PC_NEXT;
      OP_AUIPC: begin
        w_immSel = IMM_U;
        w_aSel   = 1'b1;
      end
      OP_LUI:    w_immSel = IMM_U;
`ifdef MC_CONTROL_CSR_EN
      OP_CSR: begin
        w_bSel  = 1'b0;
        w_wbSel = WB_CSR;
        if (w_f3 == 3'b101) begin
          w_csrSel = 1'b1;
          w_immSel = IMM_CSR;
        end
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic for the instruction sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (mem_ack) w_next = S_DECODE;
                else if (w_wdogHit) w_next = S_TRAP;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC:   if (w_isLoad || w_isStore) w_next = S_MEM;
                else if (w_isBranch) w_next = S_FETCH;
                else w_next = S_WB;
      S_MEM:    if (mem_ack) w_next = w_isStore ? S_FETCH : S_WB;
                else if (w_wdogHit) w_next = S_TRAP;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, watchdog and sticky trap registers; the watchdog only counts unacked requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wdog  <= '0;
      r_trap  <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      r_wdog  <= (mem_req && !mem_ack) ? r_wdog + {{(TO_W-1){1'b0}}, 1'b1} : '0;
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap  <= 1'b1;
        r_cause <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
      end
    end
  end

  // Per-state output drive; enables are also suppressed while reset is asserted.
  always_comb begin
    IRWen   = 1'b0;
    PCWen   = 1'b0;
    PCSel   = 1'b0;
    RegWen  = 1'b0;
    retired = 1'b0;
    MemRW   = MEM_READ;
    ImmSel  = 3'd0;
    ALUSel  = 4'd0;
    ASel    = 1'b0;
    BSel    = 1'b0;
    BrUn    = 1'b0;
    WBSel   = 3'd0;
    CSRSel  = 1'b0;
    if ((r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM) ||
        (r_state == S_WB)) begin
      ImmSel = w_immSel;
      ALUSel = w_aluSel;
      ASel   = w_aSel;
      BSel   = w_bSel;
      BrUn   = w_brUn;
      WBSel  = w_wbSel;
      CSRSel = w_csrSel;
    end
    case (r_state)
      S_FETCH: IRWen = mem_ack;
      S_EXEC: begin
        if (w_isBranch) begin
          PCWen   = 1'b1;
          PCSel   = w_taken;
          retired = 1'b1;
        end
      end
      S_MEM: begin
        if (w_isStore) begin
          MemRW = w_storeCode;
          if (mem_ack) begin
            PCWen   = 1'b1;
            retired = 1'b1;
          end
        end
      end
      S_WB: begin
        RegWen  = 1'b1;
        PCWen   = 1'b1;
        retired = 1'b1;
        PCSel   = w_isJump;
      end
      default: ;
    endcase
    if (!rst_n) begin
      IRWen   = 1'b0;
      PCWen   = 1'b0;
      RegWen  = 1'b0;
      retired = 1'b0;
      MemRW   = MEM_READ;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control.
// Each instruction is expanded into its expected per-cycle control trace from
// the instruction class and the chosen memory delays, then replayed against the DUT.
module tb_mc_control;

  localparam int TMO = 15;

  localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LOAD = 5'b00000,
                         OP_STORE = 5'b01000, OP_BRANCH = 5'b11000, OP_JAL = 5'b11011,
                         OP_JALR = 5'b11001, OP_AUIPC = 5'b00101, OP_LUI = 5'b01101,
                         OP_CSR = 5'b11100;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        BrEq, BrLt, mem_ack;
  logic        mem_req, IRWen, PCWen, PCSel, RegWen, BrUn, ASel, BSel, CSRSel;
  logic [2:0]  ImmSel;
  logic [3:0]  ALUSel;
  logic [3:0]  MemRW;
  logic [2:0]  WBSel;
  logic        retired, trap;
  logic [1:0]  trap_cause;

  int   checks = 0;
  int   errors = 0;
  logic needIdle;

  typedef struct packed {
    logic        ack;
    logic        chkExec;
    logic        chkWb;
    logic [12:0] exp;
  } step_t;

  step_t q[$];

  mc_control #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .BrEq(BrEq), .BrLt(BrLt),
    .mem_ack(mem_ack), .mem_req(mem_req), .IRWen(IRWen), .PCWen(PCWen), .PCSel(PCSel),
    .RegWen(RegWen), .BrUn(BrUn), .ASel(ASel), .BSel(BSel), .CSRSel(CSRSel),
    .ImmSel(ImmSel), .ALUSel(ALUSel), .MemRW(MemRW), .WBSel(WBSel), .retired(retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic step_t mk(logic ack, logic req, logic ir, logic pc, logic rg, logic ret,
                               logic pcSel, logic [3:0] mrw, logic trp, logic [1:0] cause,
                               logic ce, logic cw);
    step_t s;
    s.ack     = ack;
    s.chkExec = ce;
    s.chkWb   = cw;
    s.exp     = {req, ir, pc, rg, ret, pcSel, mrw, trp, cause};
    return s;
  endfunction

  function automatic logic isLegal(logic [4:0] opc);
`ifdef MC_CONTROL_CSR_EN
    if (opc == OP_CSR) return 1'b1;
`endif
    return opc inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                       OP_AUIPC, OP_LUI};
  endfunction

  function automatic logic [3:0] storeCode(logic [2:0] f3);
    if (f3 == 3'd0) return 4'b0001;
    if (f3 == 3'd1) return 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic branchTaken(logic [2:0] f3, logic eq, logic lt);
    if (f3 == 3'd0) return eq;
    if (f3 == 3'd1) return !eq;
    if (f3 == 3'd4 || f3 == 3'd6) return lt;
    if (f3 == 3'd5 || f3 == 3'd7) return !lt;
    return 1'b0;
  endfunction

  // Expected {ALUSel, ImmSel, ASel, BSel, BrUn} while executing.
  function automatic logic [9:0] expExec(logic [31:0] ins);
    logic [4:0] opc = ins[6:2];
    logic [2:0] f3  = ins[14:12];
    logic [3:0] alu = 4'd0;
    logic [2:0] imm = 3'd0;
    logic       a = 1'b0, b = 1'b1, un = 1'b0;
    if (opc == OP_R) begin alu = {ins[30], f3}; b = 1'b0; end
    if (opc == OP_I) alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
    if (opc == OP_STORE) imm = 3'd1;
    if (opc == OP_BRANCH) begin imm = 3'd2; a = 1'b1; un = (f3 >= 3'd6); end
    if (opc == OP_JAL) begin imm = 3'd4; a = 1'b1; end
    if (opc == OP_AUIPC) begin imm = 3'd3; a = 1'b1; end
    if (opc == OP_LUI) imm = 3'd3;
    if (opc == OP_CSR) begin b = 1'b0; imm = (f3 == 3'd5) ? 3'd5 : 3'd0; end
    return {alu, imm, a, b, un};
  endfunction

  // Expected {WBSel, CSRSel} during writeback.
  function automatic logic [3:0] expWb(logic [31:0] ins);
    logic [4:0] opc = ins[6:2];
    if (opc == OP_LOAD) return {3'd1, 1'b0};
    if (opc == OP_JAL || opc == OP_JALR) return {3'd2, 1'b0};
    if (opc == OP_CSR) return {3'd3, ins[14:12] == 3'd5};
    return {3'd0, 1'b0};
  endfunction

  task automatic applyReset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    checkOutput("rst", {19'd0, mem_req, IRWen, PCWen, RegWen, retired, PCSel, MemRW,
                        trap, trap_cause}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_ack  = 1'b0;
    needIdle = 1'b1;
  endtask

  task automatic runQueue(input logic [31:0] ins, input logic eq, input logic lt);
    instruction = ins;
    BrEq = eq;
    BrLt = lt;
    foreach (q[i]) begin
      mem_ack = q[i].ack;
      #1;
      checkOutput("ctl", {19'd0, mem_req, IRWen, PCWen, RegWen, retired, PCSel, MemRW,
                          trap, trap_cause}, {19'd0, q[i].exp});
      if (q[i].chkExec)
        checkOutput("exec", {22'd0, ALUSel, ImmSel, ASel, BSel, BrUn}, {22'd0, expExec(ins)});
      if (q[i].chkWb)
        checkOutput("wb", {28'd0, WBSel, CSRSel}, {28'd0, expWb(ins)});
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input int fDelay, input int mDelay,
                               input logic eq, input logic lt);
    logic [4:0] opc = ins[6:2];
    logic [2:0] f3  = ins[14:12];
    logic       st  = (opc == OP_STORE);
    logic       trapped = 1'b0;
    logic [1:0] cause = 2'b00;
    logic [3:0] code;
    q.delete();
    if (needIdle) q.push_back(mk(rbit(), 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
    if (fDelay >= TMO) begin
      for (int k = 0; k < TMO; k++) q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
      trapped = 1'b1;
      cause   = 2'b10;
    end else begin
      for (int k = 0; k < fDelay; k++) q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
      q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
      q.push_back(mk(rbit(), 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
      if (!isLegal(opc)) begin
        trapped = 1'b1;
        cause   = 2'b01;
      end else if (opc == OP_BRANCH) begin
        q.push_back(mk(rbit(), 0, 0, 1, 0, 1, branchTaken(f3, eq, lt), 4'd0, 0, 2'd0, 1, 0));
      end else begin
        q.push_back(mk(rbit(), 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 1, 0));
        if (opc == OP_LOAD || st) begin
          code = st ? storeCode(f3) : 4'd0;
          if (mDelay >= TMO) begin
            for (int k = 0; k < TMO; k++) q.push_back(mk(0, 1, 0, 0, 0, 0, 0, code, 0, 2'd0, 0, 0));
            trapped = 1'b1;
            cause   = 2'b10;
          end else begin
            for (int k = 0; k < mDelay; k++) q.push_back(mk(0, 1, 0, 0, 0, 0, 0, code, 0, 2'd0, 0, 0));
            q.push_back(mk(1, 1, 0, st, 0, st, 0, code, 0, 2'd0, 0, 0));
            if (!st) q.push_back(mk(rbit(), 0, 0, 1, 1, 1, 0, 4'd0, 0, 2'd0, 0, 1));
          end
        end else begin
          q.push_back(mk(rbit(), 0, 0, 1, 1, 1, (opc == OP_JAL || opc == OP_JALR), 4'd0, 0,
                         2'd0, 0, 1));
        end
      end
    end
    if (trapped)
      for (int k = 0; k < 3; k++) q.push_back(mk(rbit(), 0, 0, 0, 0, 0, 0, 4'd0, 1, cause, 0, 0));
    runQueue(ins, eq, lt);
    needIdle = 1'b0;
    if (trapped) applyReset();
  endtask

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    logic [4:0]  opcList [14];
    logic [31:0] r;
    int          fD, mD;
    opcList = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI,
                OP_CSR, 5'b00011, 5'b11111, 5'b10100, 5'b01011};
    rst_n = 1'b0;
    mem_ack = 1'b0;
    instruction = 32'd0;
    BrEq = 1'b0;
    BrLt = 1'b0;
    needIdle = 1'b1;
    applyReset();

    applyStimulus(32'h00500093, 0, 0, 0, 0);
    applyStimulus(32'h0000a103, 0, 3, 0, 0);
    applyStimulus(32'h00208023, 1, 0, 0, 0);
    applyStimulus(32'h00209463, 0, 0, 0, 0);
    applyStimulus(32'h00500093, 14, 0, 0, 0);
    applyStimulus(32'h0000a103, 0, 14, 0, 0);
    applyStimulus(32'h00500093, 20, 0, 0, 0);
    applyStimulus(32'h34015073, 0, 0, 0, 0);
    applyStimulus(32'h340090f3, 2, 0, 0, 0);
    applyStimulus(32'h0000a103, 0, 15, 0, 0);

    // Reset asserted while a store waits in MEM.
    applyReset();
    instruction = 32'h00208023;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 1, 0));
    q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'b0001, 0, 2'd0, 0, 0));
    runQueue(32'h00208023, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstmid", {19'd0, mem_req, IRWen, PCWen, RegWen, retired, PCSel, MemRW,
                           trap, trap_cause}, 32'd0);
    rst_n = 1'b1;
    needIdle = 1'b1;
    applyStimulus(32'h00500093, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      r[6:0] = {opcList[$urandom_range(0, 13)], 2'b11};
      fD = ($urandom_range(0, 24) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
      mD = ($urandom_range(0, 12) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
      applyStimulus(r, fD, mD, rbit(), rbit());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
